// File: rtl/seq_signed_alu.sv
// rtl/seq_signed_alu.sv - sequential signed ALU: single-cycle add/sub/compare/logic/shift,
// W-cycle shift-add multiply and restoring divide on magnitudes with a sign-fix state.
module seq_signed_alu #(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      mode,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [SW-1:0]   shift_value,
  input  logic            RorL,
  output logic            busy,
  output logic            done,
  output logic [2*W-1:0]  op,
  output logic [W-1:0]    rem,
  output logic [2:0]      HEL,
  output logic            div_by_zero
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t r_state, w_next;

  logic [2*W-1:0] r_op, r_acc, r_mcand;
  logic [W-1:0]   r_rem, r_mplier, r_prem, r_dvsr;
  logic [2:0]     r_hel;
  logic           r_dbz, r_is_div, r_neg_q, r_neg_r;
  logic [CW-1:0]  r_cnt;

  logic                 w_accept, w_div0, w_iter;
  logic [W-1:0]         w_amag, w_bmag, w_shl, w_sh;
  logic signed [W-1:0]  w_asr;
  logic [2*W-1:0]       w_ax, w_bx, w_single, w_q;
  logic [2:0]           w_hel;
  logic [W:0]           w_trial;

  assign w_accept = start && (r_state == IDLE);
  assign w_div0   = (mode == 3'b011) && (b == '0);
  assign w_iter   = ((mode == 3'b010) || (mode == 3'b011)) && !w_div0;

  // Magnitudes are unsigned W-bit, so -(2^(W-1)) maps cleanly to 2^(W-1).
  assign w_amag = a[W-1] ? -a : a;
  assign w_bmag = b[W-1] ? -b : b;
  assign w_ax   = {{W{a[W-1]}}, a};
  assign w_bx   = {{W{b[W-1]}}, b};
  assign w_shl  = a << shift_value;
  assign w_asr  = $signed(a) >>> shift_value;
  assign w_sh   = RorL ? w_shl : w_asr;
  assign w_hel  = {($signed(a) > $signed(b)), (a == b), ($signed(a) < $signed(b))};
  assign w_trial = {r_prem, r_mplier[W-1]} - {1'b0, r_dvsr};
  assign w_q     = {{W{1'b0}}, r_mplier};

  always_comb begin
    w_single = '0;
    case (mode)
      3'b000:  w_single = w_ax + w_bx;
      3'b001:  w_single = w_ax - w_bx;
      3'b101:  w_single = {{(2*W-1){1'b0}}, ((a != '0) && (b != '0))};
      3'b110:  w_single = {{(2*W-1){1'b0}}, ((a != '0) || (b != '0))};
      3'b111:  w_single = {{W{w_sh[W-1]}}, w_sh};
      default: w_single = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_iter ? CALC : DONE;
      CALC:    if (r_cnt == LAST) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op     <= '0;
      r_rem    <= '0;
      r_hel    <= '0;
      r_dbz    <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prem   <= '0;
      r_dvsr   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          if (w_iter) begin
            r_is_div <= mode[0];
            r_neg_q  <= a[W-1] ^ b[W-1];
            r_neg_r  <= a[W-1];
            r_mcand  <= {{W{1'b0}}, w_amag};
            // Multiplier register doubles as the dividend/quotient shifter for divide.
            r_mplier <= mode[0] ? w_amag : w_bmag;
            r_dvsr   <= w_bmag;
            r_acc    <= '0;
            r_prem   <= '0;
            r_cnt    <= '0;
          end else begin
            r_op  <= w_single;
            r_rem <= w_div0 ? a : '0;
            r_hel <= (mode == 3'b100) ? w_hel : 3'b000;
            r_dbz <= w_div0;
          end
        end
        CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_is_div) begin
            if (!w_trial[W]) begin
              r_prem   <= w_trial[W-1:0];
              r_mplier <= {r_mplier[W-2:0], 1'b1};
            end else begin
              r_prem   <= {r_prem[W-2:0], r_mplier[W-1]};
              r_mplier <= {r_mplier[W-2:0], 1'b0};
            end
          end else begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end
        end
        FIX: begin
          r_hel <= 3'b000;
          r_dbz <= 1'b0;
          if (r_is_div) begin
            r_op  <= r_neg_q ? -w_q : w_q;
            r_rem <= r_neg_r ? -r_prem : r_prem;
          end else begin
            r_op  <= r_neg_q ? -r_acc : r_acc;
            r_rem <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign op          = r_op;
  assign rem         = r_rem;
  assign HEL         = r_hel;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_signed_alu.sv
// tb/tb_seq_signed_alu.sv - directed self-checking bench for seq_signed_alu at W=8.
module tb_seq_signed_alu;

  localparam int W  = 8;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [2:0]      mode = '0;
  logic [W-1:0]    a = '0;
  logic [W-1:0]    b = '0;
  logic [SW-1:0]   shift_value = '0;
  logic            RorL = 1'b0;
  logic            busy, done, div_by_zero;
  logic [2*W-1:0]  op;
  logic [W-1:0]    rem;
  logic [2:0]      HEL;

  int total = 0;
  int bad = 0;
  int n, bc, seen;

  always #5 clk = ~clk;

  seq_signed_alu #(.W(W), .SW(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .shift_value(shift_value), .RorL(RorL), .busy(busy), .done(done),
    .op(op), .rem(rem), .HEL(HEL), .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(inout int cnt, inout int bcnt);
    while (!done && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (busy) bcnt++;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] m, input logic [7:0] aa,
                     input logic [7:0] bb, input logic [2:0] sv, input logic rl,
                     input int lat, input logic [15:0] eop, input logic [7:0] erem,
                     input logic [2:0] ehel, input logic edbz);
    int cnt, bcnt;
    @(negedge clk);
    mode = m; a = aa; b = bb; shift_value = sv; RorL = rl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    bcnt = busy ? 1 : 0;
    wait_done(cnt, bcnt);
    chk({tag, "_lat"}, cnt, lat);
    chk({tag, "_busy"}, bcnt, lat);
    chk({tag, "_op"}, op, eop);
    chk({tag, "_rem"}, rem, erem);
    chk({tag, "_hel"}, HEL, ehel);
    chk({tag, "_dbz"}, div_by_zero, edbz);
    @(negedge clk);
    chk({tag, "_pulse"}, {busy, done}, 2'b00);
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_op", op, 0);
    chk("rst_rem", rem, 0);
    chk("rst_hel", HEL, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst = 1'b1;

    run("add",     3'b000, 8'hFD, 8'h05, 3'd0, 1'b0, 1,  16'h0002, 8'h00, 3'b000, 1'b0);
    run("add_max", 3'b000, 8'h7F, 8'h7F, 3'd0, 1'b0, 1,  16'h00FE, 8'h00, 3'b000, 1'b0);
    run("sub",     3'b001, 8'hFD, 8'h05, 3'd0, 1'b0, 1,  16'hFFF8, 8'h00, 3'b000, 1'b0);
    run("sub_min", 3'b001, 8'h80, 8'h7F, 3'd0, 1'b0, 1,  16'hFF01, 8'h00, 3'b000, 1'b0);
    run("mul",     3'b010, 8'hFD, 8'h05, 3'd0, 1'b0, 10, 16'hFFF1, 8'h00, 3'b000, 1'b0);
    run("mul_mm",  3'b010, 8'h80, 8'h80, 3'd0, 1'b0, 10, 16'h4000, 8'h00, 3'b000, 1'b0);
    run("mul_mx",  3'b010, 8'h80, 8'h7F, 3'd0, 1'b0, 10, 16'hC080, 8'h00, 3'b000, 1'b0);
    run("div",     3'b011, 8'hF9, 8'h02, 3'd0, 1'b0, 10, 16'hFFFD, 8'hFF, 3'b000, 1'b0);
    run("div_min", 3'b011, 8'h80, 8'hFF, 3'd0, 1'b0, 10, 16'h0080, 8'h00, 3'b000, 1'b0);
    run("div_pn",  3'b011, 8'h07, 8'hFE, 3'd0, 1'b0, 10, 16'hFFFD, 8'h01, 3'b000, 1'b0);
    run("div0",    3'b011, 8'h09, 8'h00, 3'd0, 1'b0, 1,  16'h0000, 8'h09, 3'b000, 1'b1);
    run("cmp_lt",  3'b100, 8'hFF, 8'h01, 3'd0, 1'b0, 1,  16'h0000, 8'h00, 3'b001, 1'b0);
    run("cmp_gt",  3'b100, 8'h05, 8'hFE, 3'd0, 1'b0, 1,  16'h0000, 8'h00, 3'b100, 1'b0);
    run("cmp_eq",  3'b100, 8'h03, 8'h03, 3'd0, 1'b0, 1,  16'h0000, 8'h00, 3'b010, 1'b0);
    run("and0",    3'b101, 8'h04, 8'h00, 3'd0, 1'b0, 1,  16'h0000, 8'h00, 3'b000, 1'b0);
    run("and1",    3'b101, 8'hFF, 8'h02, 3'd0, 1'b0, 1,  16'h0001, 8'h00, 3'b000, 1'b0);
    run("or0",     3'b110, 8'h00, 8'h00, 3'd0, 1'b0, 1,  16'h0000, 8'h00, 3'b000, 1'b0);
    run("or1",     3'b110, 8'h00, 8'hFB, 3'd0, 1'b0, 1,  16'h0001, 8'h00, 3'b000, 1'b0);
    run("asr",     3'b111, 8'h90, 8'h00, 3'd2, 1'b0, 1,  16'hFFE4, 8'h00, 3'b000, 1'b0);
    run("shl",     3'b111, 8'h90, 8'h00, 3'd2, 1'b1, 1,  16'h0040, 8'h00, 3'b000, 1'b0);
    run("shl_sx",  3'b111, 8'h41, 8'h00, 3'd1, 1'b1, 1,  16'hFF82, 8'h00, 3'b000, 1'b0);
    run("asr7",    3'b111, 8'h80, 8'h00, 3'd7, 1'b0, 1,  16'hFFFF, 8'h00, 3'b000, 1'b0);

    // Abort a multiply with reset, then restart with start held high throughout.
    @(negedge clk);
    mode = 3'b010; a = 8'hFD; b = 8'h05; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    repeat (3) begin
      if (done) seen = 1;
      @(negedge clk);
    end
    if (done) seen = 1;
    #2 rst = 1'b0;
    #1;
    chk("abort_no_done", seen, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_op", op, 0);
    chk("abort_rem", rem, 0);
    chk("abort_hel", HEL, 0);
    chk("abort_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b1;
    mode = 3'b010; a = 8'hFD; b = 8'h05; start = 1'b1;
    @(negedge clk);
    n = 1;
    bc = busy ? 1 : 0;
    chk("restart_busy", busy, 1);
    a = 8'h07;
    wait_done(n, bc);
    chk("restart_lat", n, 10);
    chk("restart_busy_cnt", bc, 10);
    chk("restart_op", op, 16'hFFF1);
    @(negedge clk);
    chk("gap_idle", {busy, done}, 2'b00);
    @(negedge clk);
    chk("b2b_busy", busy, 1);
    chk("b2b_done", done, 0);
    start = 1'b0;
    n = 1;
    bc = 1;
    wait_done(n, bc);
    chk("b2b_lat", n, 10);
    chk("b2b_op", op, 16'h0023);
    @(negedge clk);
    chk("b2b_pulse", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_signed_alu.md
SEQ_SIGNED_ALU -- requirements
Module: seq_signed_alu

Interface
REQ-001 SHALL have parameter W, default 8, meaning operand width in bits (legal range 4..32).
REQ-002 SHALL have parameter SW, default $clog2(W), meaning shift-amount width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request; accepted when start=1 and busy=0.
REQ-006 SHALL have port mode  input  3  operation select, sampled at accept.
REQ-007 SHALL have ports a, b  input  W each  two's-complement signed operands, sampled at accept.
REQ-008 SHALL have port shift_value  input  SW  shift amount, sampled at accept.
REQ-009 SHALL have port RorL  input  1  shift direction (0 right, 1 left), sampled at accept.
REQ-010 SHALL have port busy  output  1  high while an accepted operation is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when result, rem and flags become valid.
REQ-012 SHALL have port op  output  2W  signed result.
REQ-013 SHALL have port rem  output  W  signed remainder (divide mode only, else 0).
REQ-014 SHALL have port HEL  output  3  compare result {a>b, a==b, a<b}, signed (compare mode only, else 0).
REQ-015 SHALL have port div_by_zero  output  1  set for a divide with b=0.

Function
REQ-016 SHALL implement modes: 000 a+b; 001 a-b; 010 a*b; 011 a/b; 100 compare; 101 logical AND (a!=0 && b!=0) in op[0]; 110 logical OR (a!=0 || b!=0) in op[0]; 111 shift of a.
REQ-017 SHALL sign-extend add/sub results to 2W bits; no overflow is possible or flagged.
REQ-018 SHALL compute multiply by iterative shift-add, one partial product per cycle, on operand magnitudes, then negate if sign(a) XOR sign(b); full 2W-bit product.
REQ-019 SHALL compute divide by iterative restoring division on magnitudes, one quotient bit per cycle; quotient truncates toward zero, sign-extended to 2W in op; rem takes the dividend's sign.
REQ-020 SHALL, for divide with b=0, skip iteration and return op=0, rem=a, div_by_zero=1 at single-cycle latency.
REQ-021 SHALL return -(2^(W-1)) / -1 as +2^(W-1) in op (fits in 2W) with rem=0.
REQ-022 SHALL, in shift mode, arithmetic-right-shift (RorL=0) or logical-left-shift (RorL=1) a by shift_value, result W bits sign-extended to 2W; shift_value >= W yields all sign bits (right) or 0 (left).
REQ-023 SHALL use FSM states IDLE, CALC, FIX (sign correction), DONE.
REQ-024 SHALL transition IDLE->DONE on accept for modes 000,001,100,101,110,111 and for divide-by-zero; IDLE->CALC for 010/011.
REQ-025 SHALL stay in CALC for exactly W cycles, then go CALC->FIX->DONE; DONE->IDLE unconditionally next cycle.
REQ-026 SHALL assert done for exactly one cycle in DONE; latency accept-edge to done: 1 cycle single-cycle modes, W+2 cycles for mul/div.
REQ-027 SHALL assert busy from the cycle after accept through the DONE cycle inclusive.
REQ-028 SHALL ignore start while busy=1; operands/mode changes during busy have no effect.
REQ-029 SHALL hold op, rem, HEL, div_by_zero stable from done until the next done; unused outputs for the mode are driven 0.
REQ-030 SHALL accept a new start in the cycle after DONE (back-to-back when start is held).

Reset
REQ-031 SHALL, on rst=0, asynchronously force state IDLE, busy=0, done=0, op=0, rem=0, HEL=0, div_by_zero=0 and clear all internal accumulators.
REQ-032 SHALL abort any in-progress operation on reset without producing done, and accept a fresh start on the first edge after rst deasserts.

Verification (W=8)
REQ-033 SHALL pass: mode 000, a=-3 (8'hFD), b=5 -> done 1 cycle after accept, op=16'h0002.
REQ-034 SHALL pass: mode 010, a=-3, b=5 -> busy 10 cycles, done 10 cycles after accept, op=16'hFFF1.
REQ-035 SHALL pass: mode 011, a=-7, b=2 -> op=16'hFFFD, rem=8'hFF; then a=-128, b=-1 -> op=16'h0080, rem=0.
REQ-036 SHALL pass: mode 011, a=9, b=0 -> done 1 cycle after accept, op=0, rem=8'h09, div_by_zero=1.
REQ-037 SHALL pass: mode 100, a=-1, b=1 -> HEL=3'b001; mode 111, a=8'h90, shift_value=2, RorL=0 -> op=16'hFFE4.
REQ-038 SHALL pass: mode 010 started, rst pulsed low at cycle 4, start re-pulsed with start held during busy -> no done before reset, outputs 0, second start ignored until done of new op.
